// File: rtl/mips_data_mem_responder_pkg.sv
// rtl/mips_data_mem_responder_pkg.sv - shared MMIO map, lane indices and decode types for the data-memory responder
package mips_data_mem_responder_pkg;

  localparam logic [15:0] MMIO_CYCLE_OFS  = 16'h0000;
  localparam logic [15:0] MMIO_LED_OFS    = 16'h0004;
  localparam logic [15:0] MMIO_STATUS_OFS = 16'h0008;

  localparam int LANE_B0    = 0;
  localparam int LANE_B3    = 3;
  localparam int LANE_COUNT = 4;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_MMIO,
    REGION_OOB
  } region_e;

  typedef enum logic {
    RD_SRC_REG,
    RD_SRC_RAM
  } rd_src_e;

  // Replace only the strobed byte lanes of a word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lane_we);
    logic [31:0] res;
    res = old_word;
    for (int i = LANE_B0; i <= LANE_B3; i++) begin
      if (lane_we[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mips_data_mem_responder_if.sv
// rtl/mips_data_mem_responder_if.sv - CPU data-memory port bundle with CPU (master) and responder (slave) views
interface mips_data_mem_responder_if;
  logic [3:0]  mem_write_en;
  logic        mem_read_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport master (
    output mem_write_en, mem_read_en, mem_addr, mem_write_data,
    input  mem_read_data
  );

  modport slave (
    input  mem_write_en, mem_read_en, mem_addr, mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/mips_data_mem_responder_byte_lane_ram.sv
// rtl/mips_data_mem_responder_byte_lane_ram.sv - single-port word RAM with byte-lane writes and synchronous read-before-write
module byte_lane_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  re,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  // The read samples the array before this edge's lane writes land.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[addr];
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/mips_data_mem_responder.sv
// rtl/mips_data_mem_responder.sv - data-memory responder: address decode, MMIO registers, cycle counter, read return
module mips_data_mem_responder
  import mips_data_mem_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter int          LED_WIDTH  = 8,
  parameter logic [15:0] MMIO_BASE  = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  mips_data_mem_responder_if.slave bus,
  output logic [LED_WIDTH-1:0] led_out,
  output logic                 bad_addr
);

  region_e        region;
  rd_src_e        rd_src;
  logic [15:0]    mmio_ofs;
  logic           mmio_mapped;
  logic           access;
  logic           set_bad;
  logic           clr_bad;
  logic           led_wr;
  logic [3:0]     ram_we;
  logic           ram_re;
  logic [31:0]    ram_rdata;
  logic [31:0]    mmio_rdata;
  logic [31:0]    rd_reg;
  logic [31:0]    cycle_cnt;
  logic [31:0]    led_merged;
  logic [LED_WIDTH-1:0] led_q;
  logic           unused_bits;

  always_comb begin
    region = REGION_OOB;
    if (bus.mem_addr[31:16] == MMIO_BASE)
      region = REGION_MMIO;
    else if (bus.mem_addr[31:ADDR_WIDTH+2] == '0)
      region = REGION_RAM;
  end

  assign mmio_ofs    = {bus.mem_addr[15:2], 2'b00};
  assign mmio_mapped = (mmio_ofs == MMIO_CYCLE_OFS) || (mmio_ofs == MMIO_LED_OFS) ||
                       (mmio_ofs == MMIO_STATUS_OFS);
  assign access      = en && (bus.mem_read_en || (|bus.mem_write_en));
  assign set_bad     = access && ((region == REGION_OOB) ||
                                  (region == REGION_MMIO && !mmio_mapped));
  assign clr_bad     = en && region == REGION_MMIO && mmio_ofs == MMIO_STATUS_OFS &&
                       bus.mem_write_en[LANE_B0] && bus.mem_write_data[0];
  assign led_wr      = en && region == REGION_MMIO && mmio_ofs == MMIO_LED_OFS &&
                       (|bus.mem_write_en);
  assign led_merged  = merge_lanes(32'(led_q), bus.mem_write_data, bus.mem_write_en);

  assign ram_we = (en && region == REGION_RAM) ? bus.mem_write_en : 4'b0000;
  assign ram_re = en && bus.mem_read_en && region == REGION_RAM;

  byte_lane_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (bus.mem_addr[ADDR_WIDTH+1:2]),
    .wdata (bus.mem_write_data),
    .rdata (ram_rdata)
  );

  always_comb begin
    mmio_rdata = 32'h0;
    case (mmio_ofs)
      MMIO_CYCLE_OFS:  mmio_rdata = cycle_cnt;
      MMIO_LED_OFS:    mmio_rdata = 32'(led_q);
      MMIO_STATUS_OFS: mmio_rdata = {31'h0, bad_addr};
      default:         mmio_rdata = 32'h0;
    endcase
  end

  // RAM data arrives from the RAM's own output register, so only its selection is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= 32'h0;
      led_q     <= '0;
      bad_addr  <= 1'b0;
      rd_src    <= RD_SRC_REG;
      rd_reg    <= 32'h0;
    end else if (en) begin
      cycle_cnt <= cycle_cnt + 32'h1;
      if (set_bad)      bad_addr <= 1'b1;
      else if (clr_bad) bad_addr <= 1'b0;
      if (led_wr) led_q <= led_merged[LED_WIDTH-1:0];
      if (bus.mem_read_en) begin
        rd_src <= (region == REGION_RAM) ? RD_SRC_RAM : RD_SRC_REG;
        rd_reg <= (region == REGION_MMIO) ? mmio_rdata : 32'h0;
      end
    end
  end

  assign bus.mem_read_data = (rd_src == RD_SRC_RAM) ? ram_rdata : rd_reg;
  assign led_out           = led_q;
  assign unused_bits       = ^{bus.mem_addr[1:0], led_merged};

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// tb/tb_mips_data_mem_responder.sv - self-checking bench for mips_data_mem_responder against a word-level model
module tb_mips_data_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic [7:0] led_out;
  logic bad_addr;

  mips_data_mem_responder_if bus();

  mips_data_mem_responder #(
    .ADDR_WIDTH (10),
    .LED_WIDTH  (8),
    .MMIO_BASE  (16'hFFFF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .bus      (bus),
    .led_out  (led_out),
    .bad_addr (bad_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_ram [1024];
  logic [31:0] m_cnt = 0;
  logic [7:0]  m_led = 0;
  logic        m_bad = 0;
  logic [31:0] m_rd  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference behaviour of one enabled clock edge, from the memory map rules.
  task automatic model_edge(input logic [3:0] we, input logic re, input logic [31:0] a,
                            input logic [31:0] d);
    bit is_mmio, is_ram, unmapped, clear;
    int word;
    logic [31:0] old;
    is_mmio  = (a[31:16] == 16'hFFFF);
    is_ram   = !is_mmio && (a < 32'h0000_1000);
    word     = int'(a[15:2]);
    unmapped = is_mmio && word > 2;
    if (re) begin
      if (is_ram) m_rd = m_ram[a[11:2]];
      else if (is_mmio && word == 0) m_rd = m_cnt;
      else if (is_mmio && word == 1) m_rd = {24'h0, m_led};
      else if (is_mmio && word == 2) m_rd = {31'h0, m_bad};
      else m_rd = 32'h0;
    end
    if (is_ram) begin
      old = m_ram[a[11:2]];
      for (int i = 0; i < 4; i++) if (we[i]) old[8*i +: 8] = d[8*i +: 8];
      m_ram[a[11:2]] = old;
    end
    if (is_mmio && word == 1 && we[0]) m_led = d[7:0];
    clear = is_mmio && word == 2 && we[0] && d[0];
    if ((re || we != 0) && ((!is_mmio && !is_ram) || unmapped)) m_bad = 1'b1;
    else if (clear) m_bad = 1'b0;
    m_cnt = m_cnt + 1;
  endtask

  task automatic cyc(input logic e, input logic [3:0] we, input logic re,
                     input logic [31:0] a, input logic [31:0] d);
    en                 = e;
    bus.mem_write_en   = we;
    bus.mem_read_en    = re;
    bus.mem_addr       = a;
    bus.mem_write_data = d;
    @(posedge clk);
    if (e) model_edge(we, re, a, d);
    #1;
    check("rdata", bus.mem_read_data, m_rd);
    check("led", {24'h0, led_out}, {24'h0, m_led});
    check("bad", {31'h0, bad_addr}, {31'h0, m_bad});
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_led = 0;
    m_bad = 0;
    m_rd  = 0;
  endtask

  logic [31:0] c1;
  logic [31:0] addr;
  int          pick;

  initial begin
    bus.mem_write_en   = 4'b0000;
    bus.mem_read_en    = 1'b0;
    bus.mem_addr       = 32'h0;
    bus.mem_write_data = 32'h0;
    #2;
    check("reset_rdata", bus.mem_read_data, 32'h0);
    check("reset_led", {24'h0, led_out}, 32'h0);
    check("reset_bad", {31'h0, bad_addr}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int w = 0; w < 16; w++) cyc(1'b1, 4'b1111, 1'b0, 32'h100 + 4*w, $urandom);

    // word write then read
    cyc(1'b1, 4'b1111, 1'b0, 32'h100, 32'hCAFEBABE);
    cyc(1'b1, 4'b0000, 1'b1, 32'h100, 32'h0);
    check("word_rd", bus.mem_read_data, 32'hCAFEBABE);

    // byte stores
    cyc(1'b1, 4'b0010, 1'b0, 32'h102, 32'h5A5A5A5A);
    cyc(1'b1, 4'b0000, 1'b1, 32'h100, 32'h0);
    check("byte1_rd", bus.mem_read_data, 32'hCAFE5ABE);
    cyc(1'b1, 4'b0001, 1'b0, 32'h103, 32'h11111111);
    cyc(1'b1, 4'b0000, 1'b1, 32'h100, 32'h0);
    check("byte0_rd", bus.mem_read_data, 32'hCAFE5A11);

    // read-before-write in one cycle, new data next cycle
    cyc(1'b1, 4'b1111, 1'b1, 32'h104, 32'h12345678);
    cyc(1'b1, 4'b0000, 1'b1, 32'h104, 32'h0);
    check("fwd_rd", bus.mem_read_data, 32'h12345678);

    // LED and CYCLE
    cyc(1'b1, 4'b1111, 1'b0, 32'hFFFF0004, 32'h000000A5);
    check("led_a5", {24'h0, led_out}, 32'hA5);
    cyc(1'b1, 4'b0000, 1'b1, 32'hFFFF0000, 32'h0);
    c1 = bus.mem_read_data;
    cyc(1'b1, 4'b0000, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 4'b0000, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 4'b0000, 1'b1, 32'hFFFF0000, 32'h0);
    check("cycle_delta", bus.mem_read_data - c1, 32'd3);

    // out-of-range, W1C, re-set
    cyc(1'b1, 4'b0000, 1'b1, 32'h00010000, 32'h0);
    check("oob_rd", bus.mem_read_data, 32'h0);
    check("oob_bad", {31'h0, bad_addr}, 32'h1);
    cyc(1'b1, 4'b0001, 1'b0, 32'hFFFF0008, 32'h00000001);
    check("w1c_bad", {31'h0, bad_addr}, 32'h0);
    cyc(1'b1, 4'b0000, 1'b1, 32'hFFFF0010, 32'h0);
    check("unmapped_bad", {31'h0, bad_addr}, 32'h1);

    // reset asserted mid-read
    cyc(1'b1, 4'b0000, 1'b1, 32'h100, 32'h0);
    bus.mem_read_en = 1'b1;
    bus.mem_addr    = 32'h104;
    #3 rst = 1'b1;
    #1;
    model_reset();
    check("midrst_rdata", bus.mem_read_data, 32'h0);
    check("midrst_led", {24'h0, led_out}, 32'h0);
    check("midrst_bad", {31'h0, bad_addr}, 32'h0);
    @(posedge clk);
    #1;
    check("rst_hold_rdata", bus.mem_read_data, 32'h0);
    rst = 1'b0;

    // en=0 freezes state
    cyc(1'b0, 4'b1111, 1'b1, 32'h100, 32'h0);
    check("en0_hold", bus.mem_read_data, 32'h0);
    cyc(1'b1, 4'b0000, 1'b1, 32'h100, 32'h0);
    check("en0_ram", bus.mem_read_data, 32'hCAFE5A11);
    cyc(1'b1, 4'b0000, 1'b1, 32'hFFFF0000, 32'h0);
    c1 = bus.mem_read_data;
    cyc(1'b0, 4'b0000, 1'b1, 32'hFFFF0000, 32'h0);
    cyc(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 4'b0000, 1'b1, 32'hFFFF0000, 32'h0);
    check("en0_cycle", bus.mem_read_data - c1, 32'd1);

    // randomized traffic over RAM, MMIO and out-of-range addresses
    for (int n = 0; n < 600; n++) begin
      pick = $urandom_range(0, 9);
      if (pick <= 5)      addr = 32'h100 + 4*$urandom_range(0, 15) + $urandom_range(0, 3);
      else if (pick <= 7) addr = 32'hFFFF0000 + 4*$urandom_range(0, 4) + $urandom_range(0, 3);
      else if (pick == 8) addr = 32'h00001000 | ($urandom & 32'h0000FFFF);
      else                addr = 32'hFFFF0008;
      cyc(($urandom_range(0, 9) != 0),
          ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom),
          1'($urandom), addr, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
